// File: rtl/perf_pkg.sv
// Shared definitions for the branch/delay-slot performance monitor:
// slot-kind encodings, counter indices and the counter increment helper.
package perf_pkg;

  localparam logic [1:0] SLOT_MANUAL = 2'd0;
  localparam logic [1:0] SLOT_AUTO   = 2'd1;
  localparam logic [1:0] SLOT_NOP    = 2'd2;

  localparam int unsigned CNT_CYCLE  = 0;
  localparam int unsigned CNT_BRANCH = 1;
  localparam int unsigned CNT_TAKEN  = 2;
  localparam int unsigned CNT_MANUAL = 3;
  localparam int unsigned CNT_AUTO   = 4;
  localparam int unsigned CNT_NOP    = 5;
  localparam int unsigned CNT_DROP   = 6;
  localparam int unsigned NUM_CNT    = 7;

  // Per-entry metadata carried next to the branch PC in the trace FIFO.
  typedef struct packed {
    logic       taken;
    logic [1:0] slot_kind;
  } trace_meta_t;

  // Increment a counter of 'width' bits held in the low bits of 'val';
  // at all-ones it either sticks (sat=1) or rolls over to zero.
  function automatic logic [63:0] cnt_inc(input logic [63:0] val,
                                          input int unsigned width,
                                          input logic sat);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    if (val == max_val) begin
      cnt_inc = sat ? max_val : 64'd0;
    end else begin
      cnt_inc = val + 64'd1;
    end
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead FIFO for branch trace entries; a full FIFO accepts a push only
// when a pop happens in the same cycle.
module trace_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 35
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [DATA_W-1:0]       push_data,
  input  logic                    pop,
  output logic [DATA_W-1:0]       head_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LVL_W = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              push_fire, pop_fire;

  assign empty     = (level_q == '0);
  assign full      = (level_q == LVL_W'(DEPTH));
  assign level     = level_q;
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    pop_fire  = pop & ~empty;
    push_fire = push & (~full | pop_fire);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q + LVL_W'(push_fire) - LVL_W'(pop_fire);
    // Power-of-two depth lets the pointers wrap by natural overflow.
    if (push_fire) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_fire)  rd_ptr_d = rd_ptr_q + AW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_fire) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/branch_slot_monitor.sv
// Branch and delay-slot performance monitor: configurable-width live counters
// with atomic snapshot / read-and-clear, plus a buffered branch trace FIFO.
module branch_slot_monitor
  import perf_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned PC_W        = 32,
  parameter int unsigned TRACE_DEPTH = 16,
  parameter int unsigned SATURATE    = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          branch_event_valid,
  input  logic [PC_W-1:0]               branch_event_pc,
  input  logic                          branch_event_taken,
  input  logic                          slot_event_is_nop,
  input  logic                          slot_event_is_auto,
  input  logic                          clear,
  input  logic                          snapshot,
  output logic                          trace_valid,
  input  logic                          trace_ready,
  output logic [PC_W-1:0]               trace_pc,
  output logic                          trace_taken,
  output logic [1:0]                    trace_slot_kind,
  output logic [$clog2(TRACE_DEPTH):0]  trace_level,
  output logic [CNT_W-1:0]              stat_cycle,
  output logic [CNT_W-1:0]              stat_branch,
  output logic [CNT_W-1:0]              stat_taken,
  output logic [CNT_W-1:0]              stat_slot_manual,
  output logic [CNT_W-1:0]              stat_slot_auto,
  output logic [CNT_W-1:0]              stat_slot_nop,
  output logic [CNT_W-1:0]              stat_trace_drop,
  output logic                          snap_done
);

  localparam int unsigned ENTRY_W = PC_W + $bits(trace_meta_t);
  localparam logic        SAT_EN  = (SATURATE != 0);

  logic [NUM_CNT-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CNT-1:0][CNT_W-1:0] stat_q, stat_d;
  logic                          snap_done_q, snap_done_d;
  logic [NUM_CNT-1:0]            inc;

  logic [1:0]         slot_kind;
  trace_meta_t        push_meta, head_meta;
  logic [ENTRY_W-1:0] head_data;
  logic               push_req, pop_fire, fifo_full, fifo_empty, drop;

  assign slot_kind = slot_event_is_nop  ? SLOT_NOP  :
                     slot_event_is_auto ? SLOT_AUTO : SLOT_MANUAL;

  assign push_meta = '{taken: branch_event_taken, slot_kind: slot_kind};
  assign push_req  = en & branch_event_valid;
  assign pop_fire  = ~fifo_empty & trace_ready;
  assign drop      = push_req & fifo_full & ~pop_fire;

  trace_fifo #(
    .DEPTH  (TRACE_DEPTH),
    .DATA_W (ENTRY_W)
  ) u_trace_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req),
    .push_data ({branch_event_pc, push_meta}),
    .pop       (trace_ready),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (trace_level)
  );

  assign {trace_pc, head_meta} = head_data;
  assign trace_taken           = head_meta.taken;
  assign trace_slot_kind       = head_meta.slot_kind;
  assign trace_valid           = ~fifo_empty;

  // Which live counters step this cycle.
  always_comb begin
    inc = '0;
    if (en) begin
      inc[CNT_CYCLE] = 1'b1;
      if (branch_event_valid) begin
        inc[CNT_BRANCH] = 1'b1;
        inc[CNT_TAKEN]  = branch_event_taken;
        case (slot_kind)
          SLOT_NOP:  inc[CNT_NOP]    = 1'b1;
          SLOT_AUTO: inc[CNT_AUTO]   = 1'b1;
          default:   inc[CNT_MANUAL] = 1'b1;
        endcase
      end
      inc[CNT_DROP] = drop;
    end
  end

  // Clear overrides any same-cycle increment; snapshot sees pre-edge values.
  always_comb begin
    cnt_d       = cnt_q;
    stat_d      = stat_q;
    snap_done_d = snapshot;
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      if (clear) begin
        cnt_d[i] = '0;
      end else if (inc[i]) begin
        cnt_d[i] = CNT_W'(cnt_inc(64'(cnt_q[i]), CNT_W, SAT_EN));
      end
    end
    if (snapshot) stat_d = cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      stat_q      <= '0;
      snap_done_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      stat_q      <= stat_d;
      snap_done_q <= snap_done_d;
    end
  end

  assign stat_cycle       = stat_q[CNT_CYCLE];
  assign stat_branch      = stat_q[CNT_BRANCH];
  assign stat_taken       = stat_q[CNT_TAKEN];
  assign stat_slot_manual = stat_q[CNT_MANUAL];
  assign stat_slot_auto   = stat_q[CNT_AUTO];
  assign stat_slot_nop    = stat_q[CNT_NOP];
  assign stat_trace_drop  = stat_q[CNT_DROP];
  assign snap_done        = snap_done_q;

endmodule
